krnl_card_rtl_rd_sequencer: RTL



---
 rtl/krnl_card_rtl_rd_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/krnl_card_rtl_rd_sequencer.sv
// Read-burst sequencer: splits an ap_start job into 4 KB-safe AXI4 read bursts,
// bounds issued-but-incomplete bursts and reports ready/done/idle back to control.
module krnl_card_rtl_rd_sequencer #(
  parameter int BEAT_BYTES      = 64,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ap_start,
  input  logic [63:0] arg_0,
  input  logic [31:0] arg_1,
  output logic        ap_ready,
  output logic        ap_done,
  output logic        ap_idle,
  output logic [63:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic        beat_hs,
  input  logic        last_hs,
  output logic        err
);

  localparam int              BB_LOG2     = $clog2(BEAT_BYTES);
  localparam int              OW          = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   MAX_OUT_C   = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]   OUT_ONE_C   = OW'(1'b1);
  localparam logic [OW-1:0]   OUT_ZERO_C  = OW'(1'b0);
  localparam logic [63:0]     ADDR_MASK_C = ~(64'(BEAT_BYTES) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Beats in the next burst: limited by work left, burst cap and distance to the 4 KB page end.
  function automatic logic [31:0] burst_beats(input logic [11:0] page_off, input logic [31:0] rem);
    logic [12:0] page_beats;
    logic [31:0] lim;
    page_beats = (13'd4096 - {1'b0, page_off}) >> BB_LOG2;
    lim        = (rem < 32'(MAX_BURST)) ? rem : 32'(MAX_BURST);
    return (lim < {19'd0, page_beats}) ? lim : {19'd0, page_beats};
  endfunction

  state_t        state_r;
  logic [63:0]   cur_addr_r;
  logic [31:0]   remaining_r;
  logic [31:0]   total_r;
  logic [31:0]   rcvd_r;
  logic [OW-1:0] outstanding_r;
  logic          err_r;
  logic          ap_ready_r;
  logic          ap_done_r;
  logic          ap_idle_r;
  logic          m_arvalid_r;
  logic [63:0]   m_araddr_r;
  logic [7:0]    m_arlen_r;

  logic [63:0]   issue_addr_s;
  logic [31:0]   issue_rem_s;
  logic [31:0]   issue_beats_s;
  logic [7:0]    issue_len_s;
  logic          ar_hs_s;
  logic [31:0]   hs_beats_s;
  logic [31:0]   remaining_dec_s;
  logic [31:0]   rcvd_nxt_s;
  logic [OW-1:0] outst_nxt_s;
  logic          last_dec_s;
  logic          err_evt_s;

  // In IDLE the next burst is sized from the incoming arguments so ARVALID can rise with ap_ready.
  assign issue_addr_s    = (state_r == ST_IDLE) ? (arg_0 & ADDR_MASK_C) : cur_addr_r;
  assign issue_rem_s     = (state_r == ST_IDLE) ? arg_1 : remaining_r;
  assign issue_beats_s   = burst_beats(issue_addr_s[11:0], issue_rem_s);
  assign issue_len_s     = 8'(issue_beats_s - 32'd1);
  assign ar_hs_s         = m_arvalid_r & m_arready;
  assign hs_beats_s      = {24'd0, m_arlen_r} + 32'd1;
  assign remaining_dec_s = remaining_r - hs_beats_s;
  assign last_dec_s      = last_hs & (outstanding_r != OUT_ZERO_C);

  // Saturating beat/burst counters and error detection for the current cycle.
  always_comb begin
    rcvd_nxt_s  = rcvd_r;
    outst_nxt_s = outstanding_r;
    err_evt_s   = 1'b0;
    if (state_r != ST_IDLE) begin
      if (beat_hs && (rcvd_r == total_r)) begin
        err_evt_s = 1'b1;
      end else if (beat_hs) begin
        rcvd_nxt_s = rcvd_r + 32'd1;
      end else begin
        rcvd_nxt_s = rcvd_r;
      end
      if (last_hs && (outstanding_r == OUT_ZERO_C)) begin
        err_evt_s = 1'b1;
      end else begin
        err_evt_s = err_evt_s;
      end
      case ({ar_hs_s, last_dec_s})
        2'b10:   outst_nxt_s = outstanding_r + OUT_ONE_C;
        2'b01:   outst_nxt_s = outstanding_r - OUT_ONE_C;
        default: outst_nxt_s = outstanding_r;
      endcase
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r       <= ST_IDLE;
      cur_addr_r    <= 64'd0;
      remaining_r   <= 32'd0;
      total_r       <= 32'd0;
      rcvd_r        <= 32'd0;
      outstanding_r <= OUT_ZERO_C;
      err_r         <= 1'b0;
      ap_ready_r    <= 1'b0;
      ap_done_r     <= 1'b0;
      ap_idle_r     <= 1'b1;
      m_arvalid_r   <= 1'b0;
      m_araddr_r    <= 64'd0;
      m_arlen_r     <= 8'd0;
    end else begin
      ap_ready_r <= 1'b0;
      if (state_r != ST_IDLE) begin
        rcvd_r        <= rcvd_nxt_s;
        outstanding_r <= outst_nxt_s;
        err_r         <= err_r | err_evt_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (ap_start) begin
            cur_addr_r    <= issue_addr_s;
            remaining_r   <= arg_1;
            total_r       <= arg_1;
            rcvd_r        <= 32'd0;
            outstanding_r <= OUT_ZERO_C;
            err_r         <= 1'b0;
            ap_ready_r    <= 1'b1;
            ap_idle_r     <= 1'b0;
            if (arg_1 == 32'd0) begin
              state_r     <= ST_DONE;
              m_arvalid_r <= 1'b0;
            end else begin
              state_r     <= ST_ISSUE;
              m_arvalid_r <= 1'b1;
              m_araddr_r  <= issue_addr_s;
              m_arlen_r   <= issue_len_s;
            end
          end else begin
            ap_idle_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // A one-cycle ARVALID gap follows every accepted burst.
          if (ar_hs_s) begin
            m_arvalid_r <= 1'b0;
            cur_addr_r  <= cur_addr_r + ({32'd0, hs_beats_s} << BB_LOG2);
            remaining_r <= remaining_dec_s;
            if (remaining_dec_s == 32'd0) begin
              state_r <= ST_DRAIN;
            end
          end else if (!m_arvalid_r) begin
            m_araddr_r  <= cur_addr_r;
            m_arlen_r   <= issue_len_s;
            m_arvalid_r <= (outst_nxt_s < MAX_OUT_C);
          end
        end
        ST_DRAIN: begin
          if ((outst_nxt_s == OUT_ZERO_C) && (rcvd_nxt_s == total_r)) begin
            state_r   <= ST_DONE;
            ap_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          // Zero-length jobs arrive here with ap_done low and pulse it one cycle later.
          if (ap_done_r) begin
            state_r   <= ST_IDLE;
            ap_done_r <= 1'b0;
            ap_idle_r <= 1'b1;
          end else begin
            ap_done_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          m_arvalid_r <= 1'b0;
          ap_done_r   <= 1'b0;
          ap_idle_r   <= 1'b1;
        end
      endcase
    end
  end

  assign ap_ready  = ap_ready_r;
  assign ap_done   = ap_done_r;
  assign ap_idle   = ap_idle_r;
  assign m_arvalid = m_arvalid_r;
  assign m_araddr  = m_araddr_r;
  assign m_arlen   = m_arlen_r;
  assign err       = err_r;

endmodule
